// File: rtl/mac_cfg_pkg.sv
// Shared definitions for the MAC configuration register slave: register map,
// command bit positions, reset values and the MAC byte-order helper.
package mac_cfg_pkg;

    localparam logic [7:0] ADDR_REV      = 8'h00;
    localparam logic [7:0] ADDR_CMD      = 8'h02;
    localparam logic [7:0] ADDR_MAC0     = 8'h03;
    localparam logic [7:0] ADDR_MAC1     = 8'h04;
    localparam logic [7:0] ADDR_FRM      = 8'h05;
    localparam logic [7:0] ADDR_PAUSE    = 8'h06;
    localparam logic [7:0] ADDR_THR_BASE = 8'h07;
    localparam logic [7:0] ADDR_IPG      = 8'h17;
    localparam logic [7:0] ADDR_TXCMD0   = 8'h3A;
    localparam logic [7:0] ADDR_TXCMD1   = 8'h3B;

    localparam int NUM_THR = 8;

    localparam int CMD_TX_ENA = 0;
    localparam int CMD_RX_ENA = 1;
    localparam int CMD_SW_RST = 13;

    localparam logic [15:0] RST_FRM_LEN = 16'd1518;
    localparam logic [15:0] RST_PAUSE   = 16'hFFFF;
    localparam logic [5:0]  RST_IPG     = 6'd12;

    // mac0 carries the first four octets LSB-first on the wire; mac1 the last two.
    function automatic logic [47:0] mac_addr_swap(input logic [31:0] m0, input logic [15:0] m1);
        return {m0[7:0], m0[15:8], m0[23:16], m0[31:24], m1[7:0], m1[15:8]};
    endfunction

endpackage

// File: rtl/mac_cfg_reg_slave_if.sv
// Configuration bus between the MAC config master and the register slave.
interface mac_cfg_reg_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rdy;
    logic [DATA_W-1:0] rdata;
    logic              rdata_vld;

    modport master (output wr_en, rd_en, addr, wdata, input rdy, rdata, rdata_vld);
    modport slave  (input wr_en, rd_en, addr, wdata, output rdy, rdata, rdata_vld);
endinterface

// File: rtl/mac_cfg_rd_pipe.sv
// Fixed-latency read-return delay line; data stages only load on a valid beat
// so the output holds the last returned word between pulses.
module mac_cfg_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT:1]             vld_pipe;
    logic [RD_LAT:1][DATA_W-1:0] dat_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_vld;
            if (in_vld) dat_pipe[1] <= in_data;
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign out_vld  = vld_pipe[RD_LAT];
    assign out_data = dat_pipe[RD_LAT];

endmodule

// File: rtl/mac_cfg_reg_slave.sv
// MAC configuration register bank: single-beat bus slave with busy gating,
// fixed read latency and a self-clearing soft reset toward the MAC core.
module mac_cfg_reg_slave
    import mac_cfg_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 8,
    parameter int          BUSY_CYC   = 2,
    parameter int          RD_LAT     = 2,
    parameter int          SW_RST_CYC = 16,
    parameter logic [31:0] REV        = 32'h0000_0901
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mac_cfg_reg_slave_if.slave      bus,
    output logic [47:0]             cfg_mac_addr,
    output logic                    cfg_tx_ena,
    output logic                    cfg_rx_ena,
    output logic                    cfg_sw_rst,
    output logic [15:0]             cfg_max_frm,
    output logic [5:0]              cfg_ipg,
    output logic [15:0]             cfg_pause_quant,
    output logic [NUM_THR*16-1:0]   cfg_fifo_thr
);

    localparam int BUSY_W = $clog2(BUSY_CYC + 1);
    localparam int SW_W   = $clog2(SW_RST_CYC + 1);
    localparam logic [DATA_W-1:0] SW_MASK = DATA_W'(1) << CMD_SW_RST;

    logic [DATA_W-1:0]           cmd_q, mac0_q, txcmd0_q, txcmd1_q;
    logic [15:0]                 mac1_q, frm_q, pause_q;
    logic [NUM_THR-1:0][15:0]    thr_q;
    logic [5:0]                  ipg_q;
    logic                        sw_rst_q;
    logic [SW_W-1:0]             sw_cnt;
    logic [BUSY_W-1:0]           busy_cnt;

    logic              rdy, accept, do_wr, do_rd;
    logic              thr_hit;
    logic [ADDR_W-1:0] thr_off;
    logic [2:0]        thr_idx;
    logic [DATA_W-1:0] rd_mux, cmd_rd;

    assign rdy     = (busy_cnt == '0);
    assign accept  = rdy && (bus.wr_en || bus.rd_en);
    assign do_wr   = accept && bus.wr_en;
    assign do_rd   = accept && bus.rd_en && !bus.wr_en;  // write wins a dual strobe
    assign bus.rdy = rdy;

    assign thr_off = bus.addr - ADDR_W'(ADDR_THR_BASE);
    assign thr_hit = (bus.addr >= ADDR_W'(ADDR_THR_BASE)) && (thr_off < ADDR_W'(NUM_THR));
    assign thr_idx = thr_off[2:0];

    // Bit 13 always reads the live soft-reset state, not the stored write bit.
    assign cmd_rd = (cmd_q & ~SW_MASK) | (sw_rst_q ? SW_MASK : '0);

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_W'(ADDR_REV):    rd_mux = DATA_W'(REV);
            ADDR_W'(ADDR_CMD):    rd_mux = cmd_rd;
            ADDR_W'(ADDR_MAC0):   rd_mux = mac0_q;
            ADDR_W'(ADDR_MAC1):   rd_mux = DATA_W'(mac1_q);
            ADDR_W'(ADDR_FRM):    rd_mux = DATA_W'(frm_q);
            ADDR_W'(ADDR_PAUSE):  rd_mux = DATA_W'(pause_q);
            ADDR_W'(ADDR_IPG):    rd_mux = DATA_W'(ipg_q);
            ADDR_W'(ADDR_TXCMD0): rd_mux = txcmd0_q;
            ADDR_W'(ADDR_TXCMD1): rd_mux = txcmd1_q;
            default:              if (thr_hit) rd_mux = DATA_W'(thr_q[thr_idx]);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if (accept) begin
            busy_cnt <= BUSY_W'(BUSY_CYC);
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - BUSY_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q    <= '0;
            mac0_q   <= '0;
            mac1_q   <= '0;
            frm_q    <= RST_FRM_LEN;
            pause_q  <= RST_PAUSE;
            thr_q    <= '0;
            ipg_q    <= RST_IPG;
            txcmd0_q <= '0;
            txcmd1_q <= '0;
        end else if (do_wr) begin
            case (bus.addr)
                ADDR_W'(ADDR_CMD):    cmd_q    <= bus.wdata;
                ADDR_W'(ADDR_MAC0):   mac0_q   <= bus.wdata;
                ADDR_W'(ADDR_MAC1):   mac1_q   <= bus.wdata[15:0];
                ADDR_W'(ADDR_FRM):    frm_q    <= bus.wdata[15:0];
                ADDR_W'(ADDR_PAUSE):  pause_q  <= bus.wdata[15:0];
                ADDR_W'(ADDR_IPG):    ipg_q    <= bus.wdata[5:0];
                ADDR_W'(ADDR_TXCMD0): txcmd0_q <= bus.wdata;
                ADDR_W'(ADDR_TXCMD1): txcmd1_q <= bus.wdata;
                default:              if (thr_hit) thr_q[thr_idx] <= bus.wdata[15:0];
            endcase
        end
    end

    // Writing bit 13 high (re)arms the countdown; writing it low never aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_rst_q <= 1'b0;
            sw_cnt   <= '0;
        end else if (do_wr && bus.addr == ADDR_W'(ADDR_CMD) && bus.wdata[CMD_SW_RST]) begin
            sw_rst_q <= 1'b1;
            sw_cnt   <= SW_W'(SW_RST_CYC);
        end else if (sw_rst_q) begin
            if (sw_cnt <= SW_W'(1)) begin
                sw_rst_q <= 1'b0;
                sw_cnt   <= '0;
            end else begin
                sw_cnt   <= sw_cnt - SW_W'(1);
            end
        end
    end

    mac_cfg_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (do_rd),
        .in_data  (rd_mux),
        .out_vld  (bus.rdata_vld),
        .out_data (bus.rdata)
    );

    assign cfg_mac_addr    = mac_addr_swap(mac0_q[31:0], mac1_q);
    assign cfg_tx_ena      = cmd_q[CMD_TX_ENA] & ~sw_rst_q;
    assign cfg_rx_ena      = cmd_q[CMD_RX_ENA] & ~sw_rst_q;
    assign cfg_sw_rst      = sw_rst_q;
    assign cfg_max_frm     = frm_q;
    assign cfg_ipg         = ipg_q;
    assign cfg_pause_quant = pause_q;
    assign cfg_fifo_thr    = thr_q;

endmodule

// File: tb/tb_mac_cfg_reg_slave.sv
// Directed bench for mac_cfg_reg_slave: stimulus pushes expected read returns,
// a negedge monitor pops and checks data and return cycle.
module tb_mac_cfg_reg_slave;

    localparam int RD_LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [47:0]  cfg_mac_addr;
    logic         cfg_tx_ena, cfg_rx_ena, cfg_sw_rst;
    logic [15:0]  cfg_max_frm, cfg_pause_quant;
    logic [5:0]   cfg_ipg;
    logic [127:0] cfg_fifo_thr;

    mac_cfg_reg_slave_if #(.DATA_W(32), .ADDR_W(8)) bus ();

    mac_cfg_reg_slave dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .cfg_mac_addr    (cfg_mac_addr),
        .cfg_tx_ena      (cfg_tx_ena),
        .cfg_rx_ena      (cfg_rx_ena),
        .cfg_sw_rst      (cfg_sw_rst),
        .cfg_max_frm     (cfg_max_frm),
        .cfg_ipg         (cfg_ipg),
        .cfg_pause_quant (cfg_pause_quant),
        .cfg_fifo_thr    (cfg_fifo_thr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Read-return monitor: every pulse must match the head entry on its due cycle.
    always @(negedge clk) begin
        if (bus.rdata_vld) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_rdata_vld: got rdata %0h at cycle %0d, no read outstanding", bus.rdata, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.rdata !== e.data || cyc != e.due) begin
                    miscompares++;
                    $display("FAIL %s: got %0h at cycle %0d expected %0h at cycle %0d",
                             e.name, bus.rdata, cyc, e.data, e.due);
                end
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: got no rdata_vld by cycle %0d expected %0h at cycle %0d", e.name, cyc, e.data, e.due);
        end
    end

    task automatic do_acc(input bit we, input bit re, input logic [7:0] a, input logic [31:0] d,
                          input bit push, input logic [31:0] exp, input string nm);
        int n = 0;
        @(negedge clk);
        while (!bus.rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_rdy_timeout: got rdy=0 for 20 cycles expected rdy=1", nm);
        end
        bus.wr_en = we; bus.rd_en = re; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        #1;
        if (push) sb.push_back('{exp, cyc + RD_LAT - 1, nm});
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        do_acc(1'b1, 1'b0, a, d, 1'b0, 32'h0, "wr");
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
        do_acc(1'b0, 1'b1, a, 32'h0, 1'b1, exp, nm);
    endtask

    task automatic chk_reset_state(input string p);
        chk({p, "_rdy"},       bus.rdy, 1);
        chk({p, "_rdata_vld"}, bus.rdata_vld, 0);
        chk({p, "_mac"},       cfg_mac_addr, 0);
        chk({p, "_tx_ena"},    cfg_tx_ena, 0);
        chk({p, "_rx_ena"},    cfg_rx_ena, 0);
        chk({p, "_sw_rst"},    cfg_sw_rst, 0);
        chk({p, "_max_frm"},   cfg_max_frm, 1518);
        chk({p, "_ipg"},       cfg_ipg, 12);
        chk({p, "_pause"},     cfg_pause_quant, 16'hFFFF);
        chk({p, "_fifo_thr"},  cfg_fifo_thr, 0);
    endtask

    task automatic wait_sw_clear(input int start, input string nm);
        int n = 0;
        while (cfg_sw_rst && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, cyc - start, 16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int a1, a3;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;
        #22 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_state("por");
        chk("por_rdata", bus.rdata, 0);

        // Revision read and busy window
        rd(8'h00, 32'h0000_0901, "rd_rev");
        @(negedge clk); chk("busy_c1", bus.rdy, 0);
        @(negedge clk); chk("busy_c2", bus.rdy, 0);
        @(negedge clk); chk("busy_c3", bus.rdy, 1);

        rd(8'h05, 32'd1518,      "rd_frm_rst");
        rd(8'h06, 32'h0000_FFFF, "rd_pause_rst");
        rd(8'h17, 32'd12,        "rd_ipg_rst");
        rd(8'h55, 32'h0,         "rd_unmapped");

        // MAC address byte order; mac1 upper half not stored
        wr(8'h03, 32'h4433_2211);
        wr(8'h04, 32'hABCD_6655);
        @(negedge clk);
        chk("mac_addr", cfg_mac_addr, 48'h1122_3344_5566);
        rd(8'h04, 32'h0000_6655, "rd_mac1");
        rd(8'h03, 32'h4433_2211, "rd_mac0");

        wr(8'h55, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("unmapped_wr_mac", cfg_mac_addr, 48'h1122_3344_5566);
        chk("unmapped_wr_frm", cfg_max_frm, 1518);
        rd(8'h55, 32'h0, "rd_unmapped_after_wr");

        // Soft reset: bit13=0 write does not abort, enables gated meanwhile
        wr(8'h02, 32'h0080_2020);
        a1 = cyc;
        chk("sw_rst_set", cfg_sw_rst, 1);
        wr(8'h02, 32'h0000_0003);
        chk("sw_rst_kept", cfg_sw_rst, 1);
        chk("tx_gated", cfg_tx_ena, 0);
        chk("rx_gated", cfg_rx_ena, 0);
        rd(8'h02, 32'h0000_2003, "rd_cmd_live_sw");
        wait_sw_clear(a1, "sw_rst_len");
        chk("tx_after_sw", cfg_tx_ena, 1);
        chk("rx_after_sw", cfg_rx_ena, 1);
        wr(8'h02, 32'h0080_0003);
        @(negedge clk);
        chk("tx_ena", cfg_tx_ena, 1);
        chk("rx_ena", cfg_rx_ena, 1);
        rd(8'h02, 32'h0080_0003, "rd_cmd");

        // Reload while active extends the pulse from the second write
        wr(8'h02, 32'h0000_2001);
        wr(8'h02, 32'h0000_2001);
        a3 = cyc;
        chk("tx_gated_reload", cfg_tx_ena, 0);
        wait_sw_clear(a3, "sw_rst_reload_len");
        chk("tx_after_reload", cfg_tx_ena, 1);
        chk("rx_after_reload", cfg_rx_ena, 0);

        // Dual strobe: write wins, no read return
        do_acc(1'b1, 1'b1, 8'h09, 32'd496, 1'b0, 32'h0, "dual");
        @(negedge clk);
        chk("thr2_dual_wr", cfg_fifo_thr[47:32], 496);
        rd(8'h09, 32'd496, "rd_thr2");
        wr(8'h07, 32'h0000_1234);
        wr(8'h0E, 32'hFFFF_BEEF);
        wr(8'h0F, 32'h0000_7777);
        @(negedge clk);
        chk("thr0", cfg_fifo_thr[15:0], 16'h1234);
        chk("thr7", cfg_fifo_thr[127:112], 16'hBEEF);
        rd(8'h0E, 32'h0000_BEEF, "rd_thr7");
        rd(8'h0F, 32'h0, "rd_past_thr");

        // IPG is 6 bits; strobes during busy are dropped
        wr(8'h17, 32'h0000_0054);
        bus.wr_en = 1'b1; bus.addr = 8'h17; bus.wdata = 32'd33;
        @(posedge clk);
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
        chk("busy_strobe_ignored", cfg_ipg, 20);
        chk("busy_strobe_rdy", bus.rdy, 1);
        rd(8'h17, 32'd20, "rd_ipg");

        wr(8'h3A, 32'hCAFE_F00D);
        wr(8'h3B, 32'h1234_5678);
        rd(8'h3A, 32'hCAFE_F00D, "rd_txcmd0");
        rd(8'h3B, 32'h1234_5678, "rd_txcmd1");

        // Async reset with a read in flight: no return, everything back to reset
        do_acc(1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 32'h0, "rd_aborted");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_state("in_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_state("post_rst");
        rd(8'h03, 32'h0, "rd_mac0_post_rst");
        rd(8'h05, 32'd1518, "rd_frm_post_rst");

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
